// File: rtl/fpga_clock_reset_seq.sv
`timescale 1ns/1ps
// fpga_clock_reset_seq: reset sequencer for a BUFGCE-gated clock domain; optional checkers via FPGA_CLOCK_RESET_SEQ_CHECK_EN
module fpga_clock_reset_seq #(
    parameter int HOLD_MARGIN  = 4,
    parameter int SETUP_MARGIN = 4,
    parameter int CE_MARGIN    = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic rst_nxt,
    output logic clk_en,
    output logic rst_out
);
    localparam int GATE_CYC = CE_MARGIN + HOLD_MARGIN;
    localparam int REL_CYC  = SETUP_MARGIN + CE_MARGIN;
    localparam int CW       = $clog2((GATE_CYC > REL_CYC ? GATE_CYC : REL_CYC) + 1);
    localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] REL_LOAD  = CW'(REL_CYC - 1);

    // HELD is the all-zero encoding so the FPGA configuration value (all registers 0)
    // is the required power-up state together with rst_out=0, clk_en=0, counter 0.
    typedef enum logic [1:0] {HELD = 2'd0, RELEASE = 2'd1, RUN = 2'd2, GATE = 2'd3} state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync;
    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   clk_en_nxt;

    assign rst_sync = sync[SYNC_STAGES-1];

    // Reset request synchronizer: cleared asynchronously, released through SYNC_STAGES flops
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) sync <= '0;
        else         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    // Next-state logic; reset requests take priority over an expiring RELEASE count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN:     if (!rst_sync) begin state_nxt = GATE; cnt_nxt = GATE_LOAD; end
            GATE:    if (cnt == '0) state_nxt = HELD;
                     else cnt_nxt = cnt - 1'b1;
            HELD:    if (rst_sync) begin state_nxt = RELEASE; cnt_nxt = REL_LOAD; end
            RELEASE: if (!rst_sync) begin state_nxt = GATE; cnt_nxt = GATE_LOAD; end
                     else if (cnt == '0) state_nxt = RUN;
                     else cnt_nxt = cnt - 1'b1;
            default: begin state_nxt = GATE; cnt_nxt = GATE_LOAD; end
        endcase
        rst_nxt    = state_nxt != HELD;
        clk_en_nxt = state_nxt == RUN;
    end

    // State, counter and registered outputs; only rst_sync influences them, no async reset
    always_ff @(posedge clk_in) begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        rst_out <= rst_nxt;
        clk_en  <= clk_en_nxt;
    end

`ifdef FPGA_CLOCK_RESET_SEQ_CHECK_EN
    int   en_age, rst_age;
    logic en_seen, rst_seen;

    // Margin checkers: cycles since clk_en was last 1 and since rst_out last moved
    always @(posedge clk_in) begin
        if (rst_nxt != rst_out && en_seen && en_age < GATE_CYC)
            $fatal(1, "rst_out edge only %0d cycles after clk_en fall", en_age);
        if (clk_en_nxt && !clk_en && rst_seen && rst_age < REL_CYC)
            $fatal(1, "clk_en rise only %0d cycles after rst_out edge", rst_age);
        en_age   <= clk_en ? 1 : (en_age < 1000 ? en_age + 1 : en_age);
        en_seen  <= en_seen | clk_en;
        rst_age  <= (rst_nxt != rst_out) ? 1 : (rst_age < 1000 ? rst_age + 1 : rst_age);
        rst_seen <= rst_seen | (rst_nxt != rst_out);
    end
`else
`endif
endmodule

// File: tb/tb_fpga_clock_reset_seq.sv
`timescale 1ns/1ps
// tb_fpga_clock_reset_seq: directed and randomized checks against a deadline-based reference model
module tb_fpga_clock_reset_seq;
    localparam int GATE_CYC = 4 + 4;
    localparam int REL_CYC  = 4 + 4;
    localparam int SYNC     = 2;

    logic clk = 0;
    logic rst_in = 0;
    logic rst_nxt, clk_en, rst_out;

    fpga_clock_reset_seq dut (
        .clk_in(clk), .rst_in(rst_in), .rst_nxt(rst_nxt), .clk_en(clk_en), .rst_out(rst_out)
    );

    always #1.25 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, failures = 0;
    int mchecks = 0, mfails = 0;
    int lows = 1;

    // Reference model: output levels plus absolute deadlines for the timed phases
    logic m_rst = 0, m_en = 0;
    bit   gating = 0;
    int   gate_end = 0, rel_end = 0;
    int   hi = 0, lows_seen = 0, nc = 0;
    logic p_rst = 0, p_en = 0;
    int   last_rst_edge = -1000, en_fall = -1000;

    task automatic mcheck(input string name, input int act, input int exp);
        mchecks++;
        if (act !== exp) begin
            mfails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, nc, act, exp);
        end
    endtask

    // Every negedge: compare outputs with the model, check margins, then predict the next edge
    always @(negedge clk) begin
        logic s;
        int k;
        nc++;
        mcheck("rst_out", rst_out, m_rst);
        mcheck("clk_en", clk_en, m_en);
        if (rst_out !== p_rst) begin
            mcheck("rst_edge_margin", (nc - en_fall >= GATE_CYC), 1);
            last_rst_edge = nc;
        end
        if (clk_en !== p_en) begin
            if (clk_en) mcheck("en_rise_margin", (nc - last_rst_edge >= REL_CYC), 1);
            else en_fall = nc;
        end
        p_rst = rst_out;
        p_en  = clk_en;
        s  = (hi >= SYNC) && (lows == lows_seen);
        hi = rst_in ? ((lows != lows_seen) ? 1 : (hi < 100 ? hi + 1 : hi)) : 0;
        lows_seen = lows;
        k = nc + 1;
        if (m_en) begin
            if (!s) begin m_en = 0; gating = 1; gate_end = k + GATE_CYC; end
        end else if (gating) begin
            if (k == gate_end) begin gating = 0; m_rst = 0; end
        end else if (!m_rst) begin
            if (s) begin m_rst = 1; rel_end = k + REL_CYC; end
        end else begin
            if (!s) begin gating = 1; gate_end = k + GATE_CYC; end
            else if (k == rel_end) m_en = 1;
        end
        mcheck("rst_nxt", rst_nxt, m_rst);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, output int at);
        @(posedge clk);
        #0.5;
        rst_in = v;
        if (!v) lows++;
        at = cyc;
    endtask

    task automatic glitch(output int at);
        @(posedge clk);
        #0.3;
        rst_in = 0;
        lows++;
        #0.3;
        rst_in = 1;
        at = cyc;
    endtask

    task automatic wait_sig(input string name, input bit sel, input logic v, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #0.2;
            if ((sel ? clk_en : rst_out) === v) begin at = cyc; break; end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    initial begin
        int c, at, r;
        #0.2;
        check("pwr_rst_out", rst_out, 0);
        check("pwr_clk_en", clk_en, 0);
        // 1: power-up release
        repeat (40) @(posedge clk);
        check("held_rst_out", rst_out, 0);
        drive(1, c);
        wait_sig("t1_rst_rise", 0, 1, 20, at);
        check("t1_rst_rise_edge", at, c + 3);
        wait_sig("t1_en_rise", 1, 1, 20, at);
        check("t1_en_rise_edge", at, c + 3 + REL_CYC);
        // 2: reset request while running
        repeat (5) @(posedge clk);
        drive(0, c);
        wait_sig("t2_en_fall", 1, 0, 20, at);
        check("t2_en_fall_edge", at, c + 1);
        wait_sig("t2_rst_fall", 0, 0, 20, at);
        check("t2_rst_fall_edge", at, c + 1 + GATE_CYC);
        drive(1, c);
        wait_sig("t2_en_rise", 1, 1, 30, at);
        check("t2_en_rise_edge", at, c + 3 + REL_CYC);
        // 3: one-cycle low request, then a sub-cycle glitch
        repeat (4) @(posedge clk);
        drive(0, c);
        drive(1, r);
        wait_sig("t3_rst_fall", 0, 0, 20, at);
        check("t3_rst_fall_edge", at, c + 1 + GATE_CYC);
        wait_sig("t3_rst_rise", 0, 1, 20, at);
        check("t3_rst_rise_edge", at, c + 2 + GATE_CYC);
        wait_sig("t3_en_rise", 1, 1, 30, at);
        check("t3_en_rise_edge", at, c + 2 + GATE_CYC + REL_CYC);
        repeat (3) @(posedge clk);
        glitch(c);
        wait_sig("t3g_en_fall", 1, 0, 20, at);
        check("t3g_en_fall_edge", at, c + 1);
        wait_sig("t3g_rst_fall", 0, 0, 20, at);
        check("t3g_rst_fall_edge", at, c + 1 + GATE_CYC);
        wait_sig("t3g_rst_rise", 0, 1, 20, at);
        check("t3g_rst_rise_edge", at, c + 2 + GATE_CYC);
        wait_sig("t3g_en_rise", 1, 1, 30, at);
        check("t3g_en_rise_edge", at, c + 2 + GATE_CYC + REL_CYC);
        // 4: reset request three cycles into RELEASE
        drive(0, c);
        wait_sig("t4_rst_fall", 0, 0, 20, at);
        drive(1, c);
        wait_sig("t4_rst_rise", 0, 1, 20, r);
        check("t4_rst_rise_edge", r, c + 3);
        repeat (2) @(posedge clk);
        drive(0, c);
        check("t4_drop_point", c, r + 3);
        wait_sig("t4_rst_fall2", 0, 0, 20, at);
        check("t4_rst_fall2_edge", at, c + 1 + GATE_CYC);
        check("t4_en_still_low", clk_en, 0);
        drive(1, c);
        wait_sig("t4_en_rise", 1, 1, 30, at);
        // 5: randomized run/reset loops
        for (int l = 0; l < 10; l++) begin
            repeat ($urandom_range(4, 40)) @(posedge clk);
            drive(0, c);
            repeat ($urandom_range(4, 40)) @(posedge clk);
            drive(1, c);
            wait_sig("t5_en_rise", 1, 1, 60, at);
            repeat (2) @(posedge clk);
            #0.2;
            check("t5_end_rst_out", rst_out, 1);
            check("t5_end_clk_en", clk_en, 1);
        end
        repeat (3) @(posedge clk);
        checks   = checks + mchecks;
        failures = failures + mfails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
